// File: rtl/parity_seq_ctrl.sv
// parity_seq_ctrl
//   Sequencing controller for the switch-to-LED parity datapath. It captures
//   the switch word when requested, or automatically when the switches differ
//   from the displayed word. It then folds the word into a single-bit
//   accumulator one bit per clock, MSB first. It publishes the word and its
//   parity together, with a one-cycle done strobe.
//
// Parameters
//   WIDTH   switch/LED word width (>= 2)
//   ODD     0: even parity (XOR of bits), 1: odd parity (inverted XOR)
//   AUTO    1: an IDLE cycle with sw != led launches a run without start
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   sw       in   switch word, sampled on the launch edge only
//   start    in   level request, sampled in IDLE only
//   led      out  last fully processed word
//   leda     out  parity of led
//   busy     out  high while shifting
//   done     out  one-cycle strobe after the last shift
//   bit_idx  out  index (0 = MSB) of the bit consumed on the next shift edge

module parity_seq_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter bit          ODD   = 1'b0,
    parameter bit          AUTO  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           sw,
    input  logic                       start,
    output logic [WIDTH-1:0]           led,
    output logic                       leda,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH)-1:0]   bit_idx
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned MSB   = WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sr_q,    sr_d;
    logic [WIDTH-1:0]   cap_q,   cap_d;
    logic               acc_q,   acc_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [WIDTH-1:0]   led_q,   led_d;
    logic               leda_q,  leda_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               launch;

    // State and datapath registers; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cap_q   <= '0;
            acc_q   <= ODD;
            idx_q   <= '0;
            led_q   <= '0;
            leda_q  <= ODD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cap_q   <= cap_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            led_q   <= led_d;
            leda_q  <= leda_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cap_d   = cap_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        led_d   = led_q;
        leda_d  = leda_q;
        launch  = start || (AUTO && (sw != led_q));

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_SHIFT;
                    sr_d    = sw;
                    cap_d   = sw;
                    acc_d   = ODD;
                    idx_d   = '0;
                end
            end
            ST_SHIFT: begin
                acc_d = acc_q ^ sr_q[MSB];
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                idx_d = idx_q + IDX_W'(1);
                // Last bit: publish word and parity together so they never disagree.
                if (idx_q == IDX_W'(WIDTH - 1)) begin
                    leda_d  = acc_q ^ sr_q[MSB];
                    led_d   = cap_q;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered copies of the upcoming state.
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    assign led     = led_q;
    assign leda    = leda_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign bit_idx = idx_q;

endmodule

// File: tb/tb_parity_seq_ctrl.sv
// Testbench for parity_seq_ctrl: three instances (even/auto, odd/manual,
// even/manual) driven by directed and random steps; instance A is checked
// every cycle against a transaction-level reference model.

module tb_parity_seq_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned IW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, start_a, leda_a, busy_a, done_a;
    logic [W-1:0]  sw_a, led_a;
    logic [IW-1:0] idx_a;
    logic          rst_b, start_b, leda_b, busy_b, done_b;
    logic [W-1:0]  sw_b, led_b;
    logic [IW-1:0] idx_b;
    logic          rst_c, start_c, leda_c, busy_c, done_c;
    logic [W-1:0]  sw_c, led_c;
    logic [IW-1:0] idx_c;

    parity_seq_ctrl #(.WIDTH(W), .ODD(1'b0), .AUTO(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .sw(sw_a), .start(start_a),
        .led(led_a), .leda(leda_a), .busy(busy_a), .done(done_a), .bit_idx(idx_a));

    parity_seq_ctrl #(.WIDTH(W), .ODD(1'b1), .AUTO(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .sw(sw_b), .start(start_b),
        .led(led_b), .leda(leda_b), .busy(busy_b), .done(done_b), .bit_idx(idx_b));

    parity_seq_ctrl #(.WIDTH(W), .ODD(1'b0), .AUTO(1'b0)) dut_c (
        .clk(clk), .rst(rst_c), .sw(sw_c), .start(start_c),
        .led(led_c), .leda(leda_c), .busy(busy_c), .done(done_c), .bit_idx(idx_c));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model for instance A: a run is "WIDTH cycles of work remaining",
    // followed by one done cycle; parity comes from a bit count.
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_led, m_cap;
    logic         m_leda;

    always @(posedge clk) begin
        if (rst_a) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_led  <= '0;
            m_leda <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_led  <= m_cap;
                m_leda <= 1'($countones(m_cap) % 2);
                m_done <= 1'b1;
            end
        end else if (start_a || (sw_a != m_led)) begin
            m_cap  <= sw_a;
            m_left <= W;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and compare instance A with the model at the falling edge.
    task automatic tick();
        @(negedge clk);
        check("a_busy", 32'(busy_a), 32'(m_left > 0));
        check("a_done", 32'(done_a), 32'(m_done));
        check("a_led",  32'(led_a),  32'(m_led));
        check("a_leda", 32'(leda_a), 32'(m_leda));
        check("a_idx",  32'(idx_a),  (m_left > 0) ? 32'(W - m_left) : 32'd0);
        check("b_excl", 32'(busy_b & done_b), 32'd0);
        check("c_excl", 32'(busy_c & done_c), 32'd0);
    endtask

    initial begin
        logic [W-1:0] wv;
        int nb, nd, cyc, d1, b2, last;
        logic prevd;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        sw_a = '0; sw_b = '0; sw_c = '0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        tick();
        tick();
        check("rst_b_leda", 32'(leda_b), 32'd1);
        check("rst_b_led",  32'(led_b),  32'd0);
        check("rst_a_idx",  32'(idx_a),  32'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Idle with sw == led: nothing launches.
        repeat (20) begin
            tick();
            check("idle_busy", 32'(busy_a), 32'd0);
            check("idle_done", 32'(done_a), 32'd0);
        end
        check("idle_led",  32'(led_a),  32'd0);
        check("idle_leda", 32'(leda_a), 32'd0);

        // Walking fill 0x80, 0xC0 ... 0xFF.
        for (int k = 1; k <= 8; k++) begin
            wv = 8'hFF;
            wv = wv << (8 - k);
            sw_a = wv;
            nb = 0;
            nd = 0;
            repeat (20) begin
                tick();
                if (busy_a) nb++;
                if (done_a) begin
                    nd++;
                    check("walk_latency", 32'(nb), 32'd8);
                end
            end
            check("walk_runs", 32'(nd), 32'd1);
            check("walk_led",  32'(led_a), 32'(wv));
            check("walk_leda", 32'(leda_a), 32'(k % 2));
        end

        // sw changes mid-run: first result unaffected, second run follows.
        sw_a = 8'h0F;
        nb = 0; nd = 0; cyc = 0; d1 = -100; b2 = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            cyc++;
            if (busy_a) begin
                nb++;
                if (nd == 1 && b2 < 0) b2 = cyc;
                if (nb == 3) sw_a = 8'h07;
            end
            if (done_a) begin
                nd++;
                if (nd == 1) begin
                    d1 = cyc;
                    check("chg_led1",  32'(led_a),  32'h0F);
                    check("chg_leda1", 32'(leda_a), 32'd0);
                end else if (nd == 2) begin
                    check("chg_led2",  32'(led_a),  32'h07);
                    check("chg_leda2", 32'(leda_a), 32'd1);
                end
            end
        end
        check("chg_runs", 32'(nd), 32'd2);
        check("chg_gap",  32'(b2 - d1), 32'd2);

        // Reset mid-run aborts without a done strobe.
        sw_a = 8'h03;
        nb = 0;
        for (int i = 0; i < 20 && nb < 4; i++) begin
            tick();
            if (busy_a) nb++;
        end
        check("abort_started", 32'(nb), 32'd4);
        rst_a = 1'b1;
        tick();
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        check("abort_led",  32'(led_a),  32'd0);
        check("abort_leda", 32'(leda_a), 32'd0);
        check("abort_idx",  32'(idx_a),  32'd0);
        rst_a = 1'b0;
        nd = 0;
        repeat (20) begin
            tick();
            if (done_a) nd++;
        end
        check("restart_runs", 32'(nd), 32'd1);
        check("restart_led",  32'(led_a),  32'h03);
        check("restart_leda", 32'(leda_a), 32'd0);

        // Odd parity, manual launch: sw alone must not start a run.
        sw_b = 8'hA5;
        repeat (5) begin
            tick();
            check("b_no_auto", 32'(busy_b), 32'd0);
        end
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("b_busy", 32'(busy_b), 32'd1);
            check("b_idx",  32'(idx_b),  32'(k));
            check("b_done_early", 32'(done_b), 32'd0);
            tick();
        end
        check("b_done", 32'(done_b), 32'd1);
        check("b_led",  32'(led_b),  32'hA5);
        check("b_leda", 32'(leda_b), 32'd1);
        tick();
        check("b_done_off", 32'(done_b), 32'd0);
        check("b_idle",     32'(busy_b), 32'd0);

        // start held high: back-to-back runs every WIDTH+2 cycles.
        sw_c = 8'h01;
        start_c = 1'b1;
        nd = 0; last = -1; prevd = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (done_c) begin
                check("c_single", 32'(prevd),  32'd0);
                check("c_leda",   32'(leda_c), 32'd1);
                check("c_led",    32'(led_c),  32'h01);
                if (last >= 0) check("c_period", 32'(i - last), 32'd10);
                last = i;
                nd++;
            end
            prevd = done_c;
        end
        check("c_runs", 32'(nd >= 4), 32'd1);
        start_c = 1'b0;

        // Random traffic on instance A against the model.
        repeat (400) begin
            tick();
            if ($urandom_range(7) == 0) sw_a = 8'($urandom);
            start_a = ($urandom_range(15) == 0);
            rst_a   = ($urandom_range(63) == 0);
        end
        rst_a = 1'b0;
        start_a = 1'b0;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_seq_ctrl.md
# parity_seq_ctrl

Sequencing controller for the switch-to-LED parity generator datapath. It captures the switch word, on request or automatically when the switches change. It then computes the word's parity serially, one bit per clock, MSB first, through a single-bit accumulator. Finally it publishes the captured word on `led` and the parity bit on `leda` with a one-cycle `done` strobe. It sits between the raw `sw` inputs and the board LEDs, replacing the purely combinational parity path with a handshaked, observable sequence.

## Interface
- `WIDTH`, 8: switch/LED word width, at least 2.
- `ODD`, 0: 0 selects even parity (`leda` = XOR of bits); 1 selects odd parity (`leda` = inverted XOR).
- `AUTO`, 1: 1 means an IDLE cycle with `sw != led` starts a run without `start`; 0 means only `start` launches a run.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `sw`  in  WIDTH  switch word; sampled only on the launch edge.
- `start`  in  1  level request; sampled only in IDLE.
- `led`  out  WIDTH  last fully processed word (registered).
- `leda`  out  1  parity of `led` per `ODD` (registered).
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle strobe; high while in DONE.
- `bit_idx`  out  clog2(WIDTH)  index of the bit consumed on the next SHIFT edge, counted from 0 = MSB.

## Operation
- Reset values: state = IDLE, `led` = 0, `leda` = `ODD`, `busy` = 0, `done` = 0, `bit_idx` = 0, shift register = 0, accumulator = `ODD`.
- States: IDLE, SHIFT, DONE.
- IDLE to SHIFT on an edge where `start` = 1, or `AUTO` = 1 and `sw != led`. On that edge:
  - shift register <= `sw`
  - capture register <= `sw`
  - accumulator <= `ODD`
  - `bit_idx` <= 0
- SHIFT, on each edge:
  - accumulator <= accumulator ^ shift register MSB
  - shift register <= shift register << 1
  - `bit_idx` <= `bit_idx` + 1
- On the SHIFT edge where `bit_idx` = WIDTH-1:
  - `leda` <= accumulator ^ shift register MSB
  - `led` <= capture register
  - `bit_idx` <= 0
  - state <= DONE
- DONE to IDLE unconditionally after one cycle.
- `start` or `sw` changes during SHIFT or DONE are ignored; no queueing.
  - With `AUTO` = 1, a change that persists is picked up in the next IDLE cycle, because `sw != led`.
  - With `AUTO` = 0, `start` must still be high in IDLE to launch a run.
- `start` held high continuously gives back-to-back runs with exactly one IDLE cycle between DONE and the next SHIFT.
- `led`/`leda` change only on the last SHIFT edge, so they are always a consistent pair. No partial result is ever visible.
- `rst` mid-run aborts the run: the reset values apply on that edge, and the partial result is discarded.
- `rst` has priority over every other condition.

## Timing
- Launch on edge E0; `busy` = 1 for the cycles after edges E0 through E(WIDTH-1), i.e. WIDTH cycles.
- Result registers update on edge E(WIDTH); `done` = 1 for exactly the one cycle following that edge; `busy` = 0 in that cycle.
- Launch-to-`done` latency is WIDTH cycles; repeat interval with `start` held is WIDTH+2 cycles.
- `busy` and `done` are never high simultaneously; `done` is never high for two consecutive cycles.
- `sw` need not be stable after E0.

## Test plan
- Reset, then hold `sw` = 0x00, `AUTO` = 1 for 20 cycles -> no run; `led` = 0x00, `leda` = 0, `busy` = `done` = 0 throughout.
- Walking fill: `sw` = 0x80, 0xC0, 0xE0 … 0xFF, each held 20 cycles, `AUTO` = 1. Required:
  - one run per step;
  - `leda` = 1,0,1,0,1,0,1,0;
  - `led` equals `sw` after each `done`;
  - `done` arrives 8 cycles after the launch edge.
- `ODD` = 1 instance, `AUTO` = 0, `sw` = 0xA5, 1-cycle `start` pulse -> after 8 busy cycles, `done` strobes; `led` = 0xA5, `leda` = 1; `bit_idx` steps 0..7 during busy.
- `AUTO` = 0, `start` held high, `sw` = 0x01 -> repeated runs with period 10 cycles; `done` exactly 1 cycle each; `leda` = 1.
- Launch with `sw` = 0x0F, then change `sw` to 0x07 at cycle 3 of SHIFT, `AUTO` = 1. Required:
  - first result `led` = 0x0F, `leda` = 0;
  - one IDLE cycle, then a second run;
  - `led` = 0x07, `leda` = 1.
- Launch `sw` = 0x03, assert `rst` at cycle 4 of SHIFT -> on the next edge all outputs take reset values and `done` never strobes. Releasing `rst` with `AUTO` = 1 restarts; the result is `led` = 0x03, `leda` = 0.
